// File: rtl/gpu_reg_pkg.sv
// Shared constants, FSM state types and decode types for the GPU AXI4-Lite register file.
package gpu_reg_pkg;

  localparam logic [11:0] CTRL_BASE       = 12'h000;
  localparam logic [11:0] STATUS_BASE     = 12'h100;
  localparam logic [11:0] IRQ_PENDING_OFS = 12'h200;
  localparam logic [11:0] IRQ_ENABLE_OFS  = 12'h204;
  localparam logic [11:0] ID_OFS          = 12'h208;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_PEND,
    SEL_EN,
    SEL_ID
  } sel_e;

  typedef struct packed {
    sel_e       sel;
    logic [5:0] idx;
  } dec_t;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpu_irq_ctrl.sv
// Sticky interrupt pending/enable registers with set-over-clear priority and a level irq output.
module gpu_irq_ctrl
  #(
    parameter int NUM_IRQ = 8
  )
  (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_event,
    input  logic [NUM_IRQ-1:0] w1c_mask,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    input  logic [NUM_IRQ-1:0] en_wmask,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] enable,
    output logic               irq
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      enable  <= '0;
    end else begin
      // An event arriving in the same cycle as its clear keeps the bit set.
      pending <= (pending & ~w1c_mask) | irq_event;
      if (en_we) begin
        enable <= (enable & ~en_wmask) | (en_wdata & en_wmask);
      end
    end
  end

  assign irq = |(pending & enable);

endmodule

// File: rtl/gpu_axi_reg_file.sv
// AXI4-Lite slave register file: CTRL (RW), STATUS (RO), IRQ pending/enable and ID.
// Optional macro GPU_REG_CTRL_PULSE_EN makes CTRL[0] a self-clearing strobe register.
module gpu_axi_reg_file
  import gpu_reg_pkg::*;
  #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_CTRL   = 4,
    parameter int NUM_STATUS = 4,
    parameter int NUM_IRQ    = 8
  )
  (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [31:0]             S_AXI_wdata,
    input  logic [3:0]              S_AXI_wstrb,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [31:0]             S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready,
    input  logic [32*NUM_STATUS-1:0] gpu_status,
    output logic [32*NUM_CTRL-1:0]  gpu_control,
    input  logic [NUM_IRQ-1:0]      irq_event,
    output logic                    irq
  );

`ifdef GPU_REG_CTRL_PULSE_EN
  localparam int CTRL_FIRST = 1;
`else
  localparam int CTRL_FIRST = 0;
`endif

  localparam logic [31:0] ID_VALUE =
    {8'(NUM_IRQ), 8'(NUM_STATUS), 8'(NUM_CTRL), 8'h01};

  function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
    dec_t        d;
    logic [31:0] a;
    logic [31:0] ofs_c;
    logic [31:0] ofs_s;
    a     = 32'(addr) & 32'hFFFF_FFFC;
    ofs_c = a - 32'(CTRL_BASE);
    ofs_s = a - 32'(STATUS_BASE);
    d.sel = SEL_NONE;
    d.idx = '0;
    // Subtracting the base first makes addresses below the base wrap out of range.
    if (ofs_c < 32'(4 * NUM_CTRL)) begin
      d.sel = SEL_CTRL;
      d.idx = 6'(ofs_c >> 2);
    end else if (ofs_s < 32'(4 * NUM_STATUS)) begin
      d.sel = SEL_STATUS;
      d.idx = 6'(ofs_s >> 2);
    end else if (a == 32'(IRQ_PENDING_OFS)) begin
      d.sel = SEL_PEND;
    end else if (a == 32'(IRQ_ENABLE_OFS)) begin
      d.sel = SEL_EN;
    end else if (a == 32'(ID_OFS)) begin
      d.sel = SEL_ID;
    end
    return d;
  endfunction

  wr_state_e          w_state, w_next;
  rd_state_e          r_state, r_next;
  logic               w_fire;
  logic               ar_fire;
  logic               arready_q;
  dec_t               w_dec;
  dec_t               r_dec;
  logic [31:0]        wmask;
  logic               ctrl_we;
  logic [31:0]        ctrl_q [NUM_CTRL];
  logic [31:0]        rd_value;
  logic               rd_err;
  logic [NUM_IRQ-1:0] irq_pending;
  logic [NUM_IRQ-1:0] irq_enable;
  logic [NUM_IRQ-1:0] w1c_mask;

  assign w_dec   = decode(S_AXI_awaddr);
  assign r_dec   = decode(S_AXI_araddr);
  assign wmask   = strb_mask(S_AXI_wstrb);
  assign ctrl_we = w_fire && (w_dec.sel == SEL_CTRL);

  // ---------------- write channel ----------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_next        = w_state;
    S_AXI_awready = 1'b0;
    S_AXI_wready  = 1'b0;
    w_fire        = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (S_AXI_awvalid && S_AXI_wvalid) begin
          S_AXI_awready = 1'b1;
          S_AXI_wready  = 1'b1;
          w_fire        = 1'b1;
          w_next        = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_bready) begin
          w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state     <= W_IDLE;
      S_AXI_bresp <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (w_fire) begin
        S_AXI_bresp <= (w_dec.sel inside {SEL_CTRL, SEL_PEND, SEL_EN}) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign S_AXI_bvalid = (w_state == W_RESP);

  // NOTE: the control array is a bank of flops driving the GPU, not a RAM, so every word is reset.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
`ifdef GPU_REG_CTRL_PULSE_EN
      ctrl_q[0] <= (ctrl_we && w_dec.idx == 6'd0) ? (S_AXI_wdata & wmask) : '0;
`endif
      for (int i = CTRL_FIRST; i < NUM_CTRL; i++) begin
        if (ctrl_we && w_dec.idx == 6'(i)) begin
          ctrl_q[i] <= (ctrl_q[i] & ~wmask) | (S_AXI_wdata & wmask);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl_out
    assign gpu_control[32*g +: 32] = ctrl_q[g];
  end

  // ---------------- interrupts ----------------
  assign w1c_mask = (w_fire && w_dec.sel == SEL_PEND) ? NUM_IRQ'(S_AXI_wdata & wmask) : '0;

  gpu_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) u_irq (
    .clk       (s_axi_aclk),
    .rst_n     (s_axi_aresetn),
    .irq_event (irq_event),
    .w1c_mask  (w1c_mask),
    .en_we     (w_fire && w_dec.sel == SEL_EN),
    .en_wdata  (NUM_IRQ'(S_AXI_wdata)),
    .en_wmask  (NUM_IRQ'(wmask)),
    .pending   (irq_pending),
    .enable    (irq_enable),
    .irq       (irq)
  );

  // ---------------- read channel ----------------
  always_comb begin
    rd_value = '0;
    rd_err   = 1'b0;
    case (r_dec.sel)
      SEL_CTRL: begin
        for (int i = 0; i < NUM_CTRL; i++) begin
          if (r_dec.idx == 6'(i)) rd_value = ctrl_q[i];
        end
      end
      SEL_STATUS: begin
        for (int i = 0; i < NUM_STATUS; i++) begin
          if (r_dec.idx == 6'(i)) rd_value = gpu_status[32*i +: 32];
        end
      end
      SEL_PEND: rd_value = 32'(irq_pending);
      SEL_EN:   rd_value = 32'(irq_enable);
      SEL_ID:   rd_value = ID_VALUE;
      default:  rd_err   = 1'b1;
    endcase
  end

  assign ar_fire = arready_q && S_AXI_arvalid;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_fire) r_next = R_DATA;
      R_DATA:  if (S_AXI_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // arready is registered so it stays low while reset is asserted.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state     <= R_IDLE;
      arready_q   <= 1'b0;
      S_AXI_rdata <= '0;
      S_AXI_rresp <= RESP_OKAY;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      if (ar_fire) begin
        S_AXI_rdata <= rd_value;
        S_AXI_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign S_AXI_arready = arready_q;
  assign S_AXI_rvalid  = (r_state == R_DATA);

endmodule

// File: tb/tb_gpu_axi_reg_file.sv
// Directed self-checking bench for gpu_axi_reg_file (default parameters).
module tb_gpu_axi_reg_file;
  import gpu_reg_pkg::*;

  logic          s_axi_aclk = 1'b0;
  logic          s_axi_aresetn;
  logic [11:0]   S_AXI_awaddr;
  logic          S_AXI_awvalid;
  logic          S_AXI_awready;
  logic [31:0]   S_AXI_wdata;
  logic [3:0]    S_AXI_wstrb;
  logic          S_AXI_wvalid;
  logic          S_AXI_wready;
  logic [1:0]    S_AXI_bresp;
  logic          S_AXI_bvalid;
  logic          S_AXI_bready;
  logic [11:0]   S_AXI_araddr;
  logic          S_AXI_arvalid;
  logic          S_AXI_arready;
  logic [31:0]   S_AXI_rdata;
  logic [1:0]    S_AXI_rresp;
  logic          S_AXI_rvalid;
  logic          S_AXI_rready;
  logic [127:0]  gpu_status;
  logic [127:0]  gpu_control;
  logic [7:0]    irq_event;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  gpu_axi_reg_file dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .S_AXI_awaddr  (S_AXI_awaddr),
    .S_AXI_awvalid (S_AXI_awvalid),
    .S_AXI_awready (S_AXI_awready),
    .S_AXI_wdata   (S_AXI_wdata),
    .S_AXI_wstrb   (S_AXI_wstrb),
    .S_AXI_wvalid  (S_AXI_wvalid),
    .S_AXI_wready  (S_AXI_wready),
    .S_AXI_bresp   (S_AXI_bresp),
    .S_AXI_bvalid  (S_AXI_bvalid),
    .S_AXI_bready  (S_AXI_bready),
    .S_AXI_araddr  (S_AXI_araddr),
    .S_AXI_arvalid (S_AXI_arvalid),
    .S_AXI_arready (S_AXI_arready),
    .S_AXI_rdata   (S_AXI_rdata),
    .S_AXI_rresp   (S_AXI_rresp),
    .S_AXI_rvalid  (S_AXI_rvalid),
    .S_AXI_rready  (S_AXI_rready),
    .gpu_status    (gpu_status),
    .gpu_control   (gpu_control),
    .irq_event     (irq_event),
    .irq           (irq)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awready"}, S_AXI_awready, 1'b0);
    check({tag, "_wready"},  S_AXI_wready,  1'b0);
    check({tag, "_bvalid"},  S_AXI_bvalid,  1'b0);
    check({tag, "_bresp"},   S_AXI_bresp,   2'b00);
    check({tag, "_arready"}, S_AXI_arready, 1'b0);
    check({tag, "_rvalid"},  S_AXI_rvalid,  1'b0);
    check({tag, "_rdata"},   S_AXI_rdata,   32'h0);
    check({tag, "_rresp"},   S_AXI_rresp,   2'b00);
    check({tag, "_control"}, gpu_control,   128'h0);
    check({tag, "_irq"},     irq,           1'b0);
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int hold, output logic [1:0] resp);
    int n;
    @(negedge s_axi_aclk);
    S_AXI_awaddr  = addr;
    S_AXI_wdata   = data;
    S_AXI_wstrb   = strb;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    S_AXI_bready  = 1'b0;
    #1;
    n = 0;
    while (!(S_AXI_awready && S_AXI_wready) && n < 20) begin
      @(negedge s_axi_aclk); #1; n++;
    end
    if (n >= 20) check("aw_timeout", 1'b1, 1'b0);
    @(posedge s_axi_aclk); #1;
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("bvalid_hold", S_AXI_bvalid, 1'b1);
      @(posedge s_axi_aclk); #1;
    end
    n = 0;
    while (!S_AXI_bvalid && n < 20) begin
      @(posedge s_axi_aclk); #1; n++;
    end
    if (n >= 20) check("b_timeout", 1'b1, 1'b0);
    resp = S_AXI_bresp;
    S_AXI_bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge s_axi_aclk);
    S_AXI_araddr  = addr;
    S_AXI_arvalid = 1'b1;
    #1;
    n = 0;
    while (!S_AXI_arready && n < 20) begin
      @(negedge s_axi_aclk); #1; n++;
    end
    if (n >= 20) check("ar_timeout", 1'b1, 1'b0);
    @(posedge s_axi_aclk); #1;
    S_AXI_arvalid = 1'b0;
    n = 0;
    while (!S_AXI_rvalid && n < 20) begin
      @(posedge s_axi_aclk); #1; n++;
    end
    if (n >= 20) check("r_timeout", 1'b1, 1'b0);
    data = S_AXI_rdata;
    resp = S_AXI_rresp;
    S_AXI_rready = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_rready = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rsp;

  initial begin
    s_axi_aresetn = 1'b0;
    S_AXI_awaddr  = '0;
    S_AXI_awvalid = 1'b0;
    S_AXI_wdata   = '0;
    S_AXI_wstrb   = '0;
    S_AXI_wvalid  = 1'b0;
    S_AXI_bready  = 1'b0;
    S_AXI_araddr  = '0;
    S_AXI_arvalid = 1'b0;
    S_AXI_rready  = 1'b0;
    irq_event     = '0;
    gpu_status    = {32'h0BAD_0003, 32'h0BAD_0002, 32'h1234_5678, 32'hCAFE_F00D};

    repeat (3) @(posedge s_axi_aclk);
    #1;
    check_reset_outputs("por");
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;

    // Reset while a write response is outstanding.
    @(negedge s_axi_aclk);
    S_AXI_awaddr  = 12'h004;
    S_AXI_wdata   = 32'h0000_00A5;
    S_AXI_wstrb   = 4'hF;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    check("burst_bvalid", S_AXI_bvalid, 1'b1);
    check("burst_ctrl1", gpu_control[63:32], 32'h0000_00A5);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    axi_write(12'h00C, 32'h1122_3344, 4'hF, 0, rsp);
    check("post_rst_bresp", rsp, RESP_OKAY);
    check("post_rst_ctrl3", gpu_control[127:96], 32'h1122_3344);
    axi_read(12'h004, rd, rsp);
    check("post_rst_ctrl1", rd, 32'h0);

    // Byte strobes and bvalid held while bready is low.
    axi_write(12'h004, 32'hDEAD_BEEF, 4'b0101, 3, rsp);
    check("strb_bresp", rsp, RESP_OKAY);
    axi_read(12'h004, rd, rsp);
    check("strb_rdata", rd, 32'h00AD_00EF);
    check("strb_rresp", rsp, RESP_OKAY);

    // Read-only and unmapped writes; status, ID and unmapped reads.
    axi_write(12'h100, 32'hFFFF_FFFF, 4'hF, 0, rsp);
    check("wr_status_resp", rsp, RESP_SLVERR);
    axi_write(12'h3FC, 32'hFFFF_FFFF, 4'hF, 0, rsp);
    check("wr_unmapped_resp", rsp, RESP_SLVERR);
    axi_write(12'h010, 32'hFFFF_FFFF, 4'hF, 0, rsp);
    check("wr_past_ctrl_resp", rsp, RESP_SLVERR);
    axi_write(12'h208, 32'hFFFF_FFFF, 4'hF, 0, rsp);
    check("wr_id_resp", rsp, RESP_SLVERR);
    check("ctrl_untouched", gpu_control, {32'h1122_3344, 32'h0, 32'h00AD_00EF, 32'h0});
    axi_read(12'h100, rd, rsp);
    check("rd_status0", rd, 32'hCAFE_F00D);
    check("rd_status0_resp", rsp, RESP_OKAY);
    axi_read(12'h3FC, rd, rsp);
    check("rd_unmapped_data", rd, 32'h0);
    check("rd_unmapped_resp", rsp, RESP_SLVERR);
    axi_read(12'h104, rd, rsp);
    check("rd_status1", rd, 32'h1234_5678);
    axi_read(12'h10C, rd, rsp);
    check("rd_status3_last", rd, 32'h0BAD_0003);
    axi_read(12'h110, rd, rsp);
    check("rd_past_status_resp", rsp, RESP_SLVERR);
    axi_read(12'h20B, rd, rsp);
    check("rd_id", rd, 32'h0804_0401);

    // Interrupts.
    axi_write(12'h204, 32'h0000_0001, 4'hF, 0, rsp);
    check("irq_en_bresp", rsp, RESP_OKAY);
    axi_read(12'h204, rd, rsp);
    check("irq_en_rd", rd, 32'h1);
    check("irq_idle", irq, 1'b0);
    @(negedge s_axi_aclk);
    irq_event = 8'h08;
    @(posedge s_axi_aclk); #1;
    irq_event = '0;
    check("irq_masked_evt", irq, 1'b0);
    axi_read(12'h200, rd, rsp);
    check("pend_masked", rd, 32'h08);
    @(negedge s_axi_aclk);
    irq_event = 8'h01;
    @(posedge s_axi_aclk); #1;
    irq_event = '0;
    check("irq_set", irq, 1'b1);
    @(negedge s_axi_aclk);
    S_AXI_awaddr  = 12'h200;
    S_AXI_wdata   = 32'h0000_0009;
    S_AXI_wstrb   = 4'hF;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    irq_event     = 8'h01;
    @(posedge s_axi_aclk); #1;
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    irq_event     = '0;
    check("irq_set_wins", irq, 1'b1);
    check("w1c_bresp", S_AXI_bresp, RESP_OKAY);
    S_AXI_bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_bready = 1'b0;
    axi_read(12'h200, rd, rsp);
    check("pend_after_race", rd, 32'h01);
    axi_write(12'h200, 32'h0000_0001, 4'hF, 0, rsp);
    check("irq_cleared", irq, 1'b0);
    axi_read(12'h200, rd, rsp);
    check("pend_cleared", rd, 32'h0);

    // Simultaneous read and write of CTRL[2].
    @(negedge s_axi_aclk);
    S_AXI_awaddr  = 12'h008;
    S_AXI_wdata   = 32'h0000_0055;
    S_AXI_wstrb   = 4'hF;
    S_AXI_araddr  = 12'h008;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    S_AXI_arvalid = 1'b1;
    #1;
    check("sim_arready", S_AXI_arready, 1'b1);
    check("sim_awready", S_AXI_awready, 1'b1);
    @(posedge s_axi_aclk); #1;
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    S_AXI_arvalid = 1'b0;
    check("sim_rvalid", S_AXI_rvalid, 1'b1);
    check("sim_bvalid", S_AXI_bvalid, 1'b1);
    check("sim_old_data", S_AXI_rdata, 32'h0);
    S_AXI_rready = 1'b1;
    S_AXI_bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_rready = 1'b0;
    S_AXI_bready = 1'b0;
    axi_read(12'h008, rd, rsp);
    check("sim_new_data", rd, 32'h55);

    // CTRL[0]: strobe in the pulse build, persistent otherwise.
    @(negedge s_axi_aclk);
    S_AXI_awaddr  = 12'h000;
    S_AXI_wdata   = 32'h0000_0003;
    S_AXI_wstrb   = 4'hF;
    S_AXI_awvalid = 1'b1;
    S_AXI_wvalid  = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_awvalid = 1'b0;
    S_AXI_wvalid  = 1'b0;
    check("ctrl0_first", gpu_control[1:0], 2'b11);
    @(posedge s_axi_aclk); #1;
`ifdef GPU_REG_CTRL_PULSE_EN
    check("ctrl0_second", gpu_control[1:0], 2'b00);
`else
    check("ctrl0_second", gpu_control[1:0], 2'b11);
`endif
    S_AXI_bready = 1'b1;
    @(posedge s_axi_aclk); #1;
    S_AXI_bready = 1'b0;
    axi_read(12'h000, rd, rsp);
`ifdef GPU_REG_CTRL_PULSE_EN
    check("ctrl0_readback", rd, 32'h0);
`else
    check("ctrl0_readback", rd, 32'h3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
